// File: rtl/collision_checker.sv
// Collision checker: compares the T-rex against the leftmost obstacle.
// A coarse outer-box test gates a fine pass over every obstacle-box /
// T-rex-box pair, one pair per clock, stopping at the first overlap.
module collision_checker #(
    parameter int OBS_BOXES  = 5,
    parameter int TREX_BOXES = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      check,
    input  logic                      has_obstacle,
    input  logic signed [10:0]        obs_x,
    input  logic [9:0]                obs_y,
    input  logic [9:0]                obs_w,
    input  logic [9:0]                obs_h,
    input  logic [OBS_BOXES*40-1:0]   obs_box,
    input  logic signed [10:0]        trex_x,
    input  logic [9:0]                trex_y,
    input  logic [9:0]                trex_w,
    input  logic [9:0]                trex_h,
    input  logic [TREX_BOXES*40-1:0]  trex_box,
    output logic                      busy,
    output logic                      done,
    output logic                      hit,
    output logic                      crash
);

    localparam int IW = (OBS_BOXES > 1) ? $clog2(OBS_BOXES) : 1;
    localparam int JW = (TREX_BOXES > 1) ? $clog2(TREX_BOXES) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(OBS_BOXES - 1);
    localparam logic [JW-1:0] J_LAST = JW'(TREX_BOXES - 1);

    typedef enum logic [1:0] {IDLE, OUTER, INNER, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic          hit_q, hit_d;
    logic          crash_q, crash_d;

    // Latched scene; only these copies are evaluated.
    logic signed [10:0]       obs_x_q, trex_x_q;
    logic [9:0]               obs_y_q, obs_w_q, obs_h_q;
    logic [9:0]               trex_y_q, trex_w_q, trex_h_q;
    logic [OBS_BOXES*40-1:0]  obs_box_q;
    logic [TREX_BOXES*40-1:0] trex_box_q;

    logic load;
    logic outer_hit;
    logic pair_hit;
    logic [39:0] obs_arr  [OBS_BOXES];
    logic [39:0] trex_arr [TREX_BOXES];
    logic [39:0] obs_sel, trex_sel;

    // Sign-extend an 11-bit signed coordinate to the 13-bit compare width.
    function automatic logic signed [12:0] sext11(input logic signed [10:0] v);
        return $signed({{2{v[10]}}, v});
    endfunction

    // Zero-extend an unsigned 10-bit field to the 13-bit compare width.
    function automatic logic signed [12:0] ext10(input logic [9:0] v);
        return $signed({3'b000, v});
    endfunction

    // Strict axis-aligned overlap; touching edges and empty boxes never hit.
    function automatic logic boxes_overlap(
        input logic signed [12:0] ax, input logic signed [12:0] ay,
        input logic [9:0]         aw, input logic [9:0]         ah,
        input logic signed [12:0] bx, input logic signed [12:0] by,
        input logic [9:0]         bw, input logic [9:0]         bh
    );
        logic nonempty;
        nonempty = (aw != 10'd0) && (ah != 10'd0) && (bw != 10'd0) && (bh != 10'd0);
        return nonempty
            && (ax < bx + ext10(bw)) && (ax + ext10(aw) > bx)
            && (ay < by + ext10(bh)) && (ay + ext10(ah) > by);
    endfunction

    for (genvar g = 0; g < OBS_BOXES; g++) begin : g_obs_unpack
        assign obs_arr[g] = obs_box_q[g*40 +: 40];
    end
    for (genvar g = 0; g < TREX_BOXES; g++) begin : g_trex_unpack
        assign trex_arr[g] = trex_box_q[g*40 +: 40];
    end

    assign load     = (state_q == IDLE) && check;
    assign obs_sel  = obs_arr[i_q];
    assign trex_sel = trex_arr[j_q];

    assign outer_hit = boxes_overlap(
        sext11(trex_x_q), ext10(trex_y_q), trex_w_q, trex_h_q,
        sext11(obs_x_q),  ext10(obs_y_q),  obs_w_q,  obs_h_q);

    assign pair_hit = boxes_overlap(
        sext11(obs_x_q) + ext10(obs_sel[39:30]), ext10(obs_y_q) + ext10(obs_sel[29:20]),
        obs_sel[19:10], obs_sel[9:0],
        sext11(trex_x_q) + ext10(trex_sel[39:30]), ext10(trex_y_q) + ext10(trex_sel[29:20]),
        trex_sel[19:10], trex_sel[9:0]);

    // Capture the scene on an accepted check.
    always_ff @(posedge clk) begin
        if (load) begin
            obs_x_q    <= obs_x;
            obs_y_q    <= obs_y;
            obs_w_q    <= obs_w;
            obs_h_q    <= obs_h;
            obs_box_q  <= obs_box;
            trex_x_q   <= trex_x;
            trex_y_q   <= trex_y;
            trex_w_q   <= trex_w;
            trex_h_q   <= trex_h;
            trex_box_q <= trex_box;
        end
    end

    // Control state: FSM, pair indices, result and sticky crash flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            hit_q   <= 1'b0;
            crash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            hit_q   <= hit_d;
            crash_q <= crash_d;
        end
    end

    // Next-state logic: outer gate, then pair scan with j running fastest.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        hit_d   = hit_q;
        crash_d = crash_q;
        unique case (state_q)
            IDLE: begin
                if (check) begin
                    hit_d   = 1'b0;
                    state_d = has_obstacle ? OUTER : DONE;
                end
            end
            OUTER: begin
                if (outer_hit) begin
                    state_d = INNER;
                    i_d     = '0;
                    j_d     = '0;
                end else begin
                    state_d = DONE;
                end
            end
            INNER: begin
                if (pair_hit) begin
                    state_d = DONE;
                    hit_d   = 1'b1;
                    crash_d = 1'b1;
                end else if (j_q == J_LAST) begin
                    j_d = '0;
                    if (i_q == I_LAST) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign hit   = hit_q;
    assign crash = crash_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker with hand-computed expectations.
module tb_collision_checker;

    localparam int OB = 5;
    localparam int TB = 6;

    logic               clk;
    logic               rst;
    logic               check;
    logic               has_obstacle;
    logic signed [10:0] obs_x;
    logic [9:0]         obs_y, obs_w, obs_h;
    logic [OB*40-1:0]   obs_box;
    logic signed [10:0] trex_x;
    logic [9:0]         trex_y, trex_w, trex_h;
    logic [TB*40-1:0]   trex_box;
    logic               busy, done, hit, crash;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int ndone;

    collision_checker #(.OBS_BOXES(OB), .TREX_BOXES(TB)) dut (
        .clk(clk), .rst(rst), .check(check), .has_obstacle(has_obstacle),
        .obs_x(obs_x), .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h),
        .obs_box(obs_box),
        .trex_x(trex_x), .trex_y(trex_y), .trex_w(trex_w), .trex_h(trex_h),
        .trex_box(trex_box),
        .busy(busy), .done(done), .hit(hit), .crash(crash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk_box(input int x, input int y, input int w, input int h);
        return {10'(x), 10'(y), 10'(w), 10'(h)};
    endfunction

    task automatic set_trex(input int x, input int y, input int w, input int h);
        trex_x = 11'(x); trex_y = 10'(y); trex_w = 10'(w); trex_h = 10'(h);
    endtask

    task automatic set_obs(input int x, input int y, input int w, input int h);
        obs_x = 11'(x); obs_y = 10'(y); obs_w = 10'(w); obs_h = 10'(h);
    endtask

    task automatic fill_obs(input logic [39:0] b);
        for (int k = 0; k < OB; k++) obs_box[k*40 +: 40] = b;
    endtask

    task automatic fill_trex(input logic [39:0] b);
        for (int k = 0; k < TB; k++) trex_box[k*40 +: 40] = b;
    endtask

    // One-cycle check pulse; returns half a cycle after the accepting edge.
    task automatic pulse_check();
        @(negedge clk);
        check = 1'b1;
        @(negedge clk);
        check = 1'b0;
    endtask

    // Cycles from the accepting edge until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; check = 1'b0; has_obstacle = 1'b0;
        set_obs(0, 0, 0, 0); set_trex(0, 0, 0, 0);
        obs_box = '0; trex_box = '0;
        repeat (2) @(negedge clk);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_hit", int'(hit), 0);
        chk_eq("rst_crash", int'(crash), 0);
        rst = 1'b0;

        // No obstacle: done after 1 cycle, no hit.
        has_obstacle = 1'b0;
        pulse_check();
        wait_done(lat);
        chk_eq("noobs_lat", lat, 1);
        chk_eq("noobs_hit", int'(hit), 0);
        chk_eq("noobs_crash", int'(crash), 0);
        chk_eq("noobs_busy", int'(busy), 1);
        @(negedge clk);
        chk_eq("noobs_done_1cyc", int'(done), 0);
        chk_eq("noobs_idle", int'(busy), 0);

        // Outer miss: obstacle far to the right.
        has_obstacle = 1'b1;
        set_trex(50, 93, 44, 47); fill_trex(mk_box(0, 0, 44, 47));
        set_obs(300, 105, 17, 35); fill_obs(mk_box(0, 0, 17, 35));
        pulse_check();
        wait_done(lat);
        chk_eq("outmiss_lat", lat, 2);
        chk_eq("outmiss_hit", int'(hit), 0);

        // Only the last pair (obs 4, trex 5) overlaps: full scan.
        set_obs(60, 100, 17, 35);
        fill_obs(mk_box(0, 0, 2, 2));
        obs_box[4*40 +: 40] = mk_box(10, 20, 5, 5);
        fill_trex(mk_box(40, 40, 4, 4));
        trex_box[5*40 +: 40] = mk_box(20, 27, 5, 5);
        pulse_check();
        wait_done(lat);
        chk_eq("lastpair_lat", lat, 32);
        chk_eq("lastpair_hit", int'(hit), 1);
        chk_eq("lastpair_crash", int'(crash), 1);
        repeat (3) @(negedge clk);
        chk_eq("lastpair_hit_hold", int'(hit), 1);
        chk_eq("lastpair_done_low", int'(done), 0);

        // First pair overlaps: early exit.
        fill_obs(mk_box(0, 0, 17, 35));
        fill_trex(mk_box(0, 0, 44, 47));
        pulse_check();
        wait_done(lat);
        chk_eq("firstpair_lat", lat, 3);
        chk_eq("firstpair_hit", int'(hit), 1);

        // Outer edges touching: miss, crash stays sticky.
        set_obs(94, 105, 17, 35);
        pulse_check();
        wait_done(lat);
        chk_eq("touch_outer_lat", lat, 2);
        chk_eq("touch_outer_hit", int'(hit), 0);
        chk_eq("touch_outer_crash", int'(crash), 1);

        // Outer overlaps by 1, inner boxes only touch: full scan, no hit.
        set_obs(93, 105, 17, 35);
        fill_obs(mk_box(1, 0, 16, 35));
        pulse_check();
        wait_done(lat);
        chk_eq("touch_inner_lat", lat, 32);
        chk_eq("touch_inner_hit", int'(hit), 0);

        // Zero-width obstacle boxes sitting inside the T-rex never hit.
        set_obs(60, 100, 17, 35);
        fill_obs(mk_box(5, 5, 0, 10));
        pulse_check();
        wait_done(lat);
        chk_eq("zerow_lat", lat, 32);
        chk_eq("zerow_hit", int'(hit), 0);

        // Negative obstacle x overlapping a T-rex at x=0.
        set_trex(0, 93, 44, 47); fill_trex(mk_box(0, 0, 44, 47));
        set_obs(-10, 105, 17, 35); fill_obs(mk_box(0, 0, 17, 35));
        pulse_check();
        wait_done(lat);
        chk_eq("negx_lat", lat, 3);
        chk_eq("negx_hit", int'(hit), 1);

        // check held high across the whole evaluation: exactly one done.
        repeat (2) @(negedge clk);
        check = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ndone += int'(done);
            if (k == 4) check = 1'b0;
        end
        chk_eq("busy_check_dones", ndone, 1);
        chk_eq("busy_check_hit", int'(hit), 1);

        // Reset during INNER at pair (2,3): abort, then a fresh check works.
        set_trex(50, 93, 44, 47);
        set_obs(60, 100, 17, 35);
        fill_obs(mk_box(5, 5, 0, 10));
        pulse_check();
        repeat (16) @(negedge clk);
        chk_eq("abort_busy_before", int'(busy), 1);
        chk_eq("abort_crash_before", int'(crash), 1);
        rst = 1'b1;
        #1;
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_crash", int'(crash), 0);
        chk_eq("abort_done", int'(done), 0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ndone += int'(done);
        end
        chk_eq("abort_no_done", ndone, 0);
        rst = 1'b0;
        has_obstacle = 1'b0;
        check = 1'b1;
        @(negedge clk);
        check = 1'b0;
        chk_eq("post_rst_done", int'(done), 1);
        chk_eq("post_rst_hit", int'(hit), 0);
        chk_eq("post_rst_crash", int'(crash), 0);
        @(negedge clk);
        chk_eq("post_rst_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collision_checker.md
COLLISION_CHECKER -- requirements
Module: collision_checker

Interface
REQ-001 The block SHALL have parameter OBS_BOXES, default 5, giving the number of collision boxes per obstacle.
REQ-002 The block SHALL have parameter TREX_BOXES, default 6, giving the number of collision boxes for the T-rex.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port check, input, 1 bit: request pulse to start one collision evaluation.
REQ-006 The block SHALL have port has_obstacle, input, 1 bit: the leftmost obstacle slot is valid.
REQ-007 The block SHALL have ports obs_x signed 11 and obs_y 10, both inputs: the leftmost obstacle origin.
REQ-008 The block SHALL have ports obs_w 10 and obs_h 10, both inputs: the leftmost obstacle size.
REQ-009 The block SHALL have port obs_box, input, OBS_BOXES x {x 10, y 10, w 10, h 10}: obstacle boxes relative to the obstacle origin.
REQ-010 The block SHALL have ports trex_x signed 11, trex_y 10, trex_w 10 and trex_h 10, all inputs: the T-rex origin and size.
REQ-011 The block SHALL have port trex_box, input, TREX_BOXES x {x, y, w, h}, 10 bits each: T-rex boxes relative to the T-rex origin.
REQ-012 The block SHALL have port busy, output, 1 bit: an evaluation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of an evaluation.
REQ-014 The block SHALL have port hit, output, 1 bit: the result of the last evaluation, valid from the done cycle until the next accepted check.
REQ-015 The block SHALL have port crash, output, 1 bit: sticky crash flag fed to the horizon and game FSM.

Function
REQ-016 The state machine SHALL have states IDLE, OUTER, INNER and DONE.
REQ-017 In IDLE, check=1 SHALL latch all obs_*, trex_* and box inputs into internal registers, and the block SHALL evaluate only these latched copies.
REQ-018 IDLE with check=1 and has_obstacle=0 SHALL go to DONE with hit=0.
REQ-019 IDLE with check=1 and has_obstacle=1 SHALL go to OUTER.
REQ-020 OUTER SHALL test the outer boxes (trex_x, trex_y, trex_w, trex_h) against (obs_x, obs_y, obs_w, obs_h).
REQ-021 On an OUTER miss the block SHALL go to DONE with hit=0; on an OUTER overlap it SHALL go to INNER with i=0, j=0.
REQ-022 INNER SHALL test exactly one pair per cycle: obstacle box i against T-rex box j, each offset by its own origin.
REQ-023 INNER SHALL iterate j fastest; on j=TREX_BOXES-1 it SHALL reset j to 0 and increment i.
REQ-024 The first overlapping pair in INNER SHALL send the block to DONE with hit=1, with no further pairs tested.
REQ-025 Completing the last pair (i=OBS_BOXES-1, j=TREX_BOXES-1) with no overlap SHALL send the block to DONE with hit=0.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 The overlap test SHALL be strict: a.x < b.x+b.w AND a.x+a.w > b.x AND a.y < b.y+b.h AND a.y+a.h > b.y.
REQ-028 All overlap sums SHALL be computed signed at 13 bits with no truncation, so negative obstacle x (partially off-screen left) compares correctly.
REQ-029 A box with w=0 or h=0 SHALL never overlap anything.
REQ-030 busy SHALL be 1 in OUTER, INNER and DONE.
REQ-031 check asserted while busy=1 SHALL be ignored: it is neither queued nor allowed to restart the evaluation.
REQ-032 Latency from the accepted check to done SHALL be 1 cycle for has_obstacle=0.
REQ-033 Latency from the accepted check to done SHALL be 2 cycles for an outer miss.
REQ-034 Latency from the accepted check to done SHALL be at most 2+OBS_BOXES*TREX_BOXES cycles with inner testing, i.e. 32 at the defaults.
REQ-035 crash SHALL set in the done cycle when hit=1 and SHALL remain 1 until rst, regardless of later evaluations.
REQ-036 When crash=1, check SHALL still be accepted, and hit SHALL report fresh results.

Reset
REQ-037 rst SHALL asynchronously force state=IDLE, i=0, j=0, busy=0, done=0, hit=0 and crash=0.
REQ-038 rst asserted mid-evaluation SHALL abort it, with no done pulse emitted.
REQ-039 After rst deasserts, check SHALL be accepted on the first rising edge.

Verification
REQ-040 has_obstacle=0, check pulse -> done 1 cycle later, hit=0, crash=0.
REQ-041 T-rex at (50,93), size 44x47; obstacle at (300,105), size 17x35; check -> done 2 cycles later, hit=0.
REQ-042 Outer boxes overlap, only the pair obstacle box 4 / T-rex box 5 overlaps -> done exactly 32 cycles after check, hit=1, crash=1 and staying 1.
REQ-043 Edge-touching case, obstacle at obs_x = trex_x+trex_w with all boxes full-size -> hit=0.
REQ-044 Obstacle at obs_x=-10 with w=17 overlapping a T-rex at x=0 -> hit=1; checks pulsed while busy produce exactly one done.
REQ-045 rst asserted during INNER at pair (2,3) -> busy=0 and crash=0 immediately, no done pulse; a new check then completes normally.
